// File: rtl/beam_pkg.sv
// Shared definitions for the beamformer summing stage: output width derivation and FSM states.
package beam_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } beam_state_e;

  // Full-precision width of a weighted sum over nc channels.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned ww,
                                            input int unsigned nc);
    return dw + ww + $clog2(nc);
  endfunction

endpackage

// File: rtl/adder_tree.sv
// Registered binary adder tree, one register level per tree level, with a valid bit alongside.
module adder_tree #(
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned IN_WIDTH   = 24,
  localparam int unsigned OUT_WIDTH = IN_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_flat_i,
  input  logic                          in_valid_i,
  output logic signed [OUT_WIDTH-1:0]   sum_o,
  output logic                          valid_o
);

  localparam int unsigned Levels = $clog2(NUM_INPUTS);

  // Heap-ordered nodes: 1 is the root, children of i are 2i and 2i+1, leaves sit at N..2N-1.
  logic signed [OUT_WIDTH-1:0] node_q [1:NUM_INPUTS-1];
  logic signed [OUT_WIDTH-1:0] node_c [1:2*NUM_INPUTS-1];
  logic        [Levels-1:0]    valid_q;

  always_comb begin
    node_c = '{default: '0};
    for (int i = 1; i < NUM_INPUTS; i++) begin
      node_c[i] = node_q[i];
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      node_c[NUM_INPUTS+i] = OUT_WIDTH'($signed(in_flat_i[i*IN_WIDTH +: IN_WIDTH]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 1; i < NUM_INPUTS; i++) begin
        node_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 1; i < NUM_INPUTS; i++) begin
        node_q[i] <= node_c[2*i] + node_c[2*i+1];
      end
      valid_q <= (valid_q << 1) | Levels'(in_valid_i);
    end
  end

  assign sum_o   = node_q[1];
  assign valid_o = valid_q[Levels-1];

endmodule

// File: rtl/beam_sum.sv
// Apodized delay-and-sum: weights each channel, sums through a registered tree and tracks
// the scanline sample index through an IDLE/RUN/FLUSH controller.
module beam_sum
  import beam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned NUM_SAMPLES  = 256,
  localparam int unsigned ChW       = $clog2(NUM_CHANNELS),
  localparam int unsigned IdxW      = $clog2(NUM_SAMPLES),
  localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH, WEIGHT_WIDTH, NUM_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   delayed_flat,
  input  logic [NUM_CHANNELS-1:0]              valid_b,
  input  logic                                 w_we,
  input  logic [ChW-1:0]                       w_addr,
  input  logic [WEIGHT_WIDTH-1:0]              w_data,
  output logic signed [SUM_WIDTH-1:0]          sum_out,
  output logic                                 sum_valid,
  output logic [IdxW-1:0]                      sample_idx,
  output logic                                 line_done,
  output logic                                 busy
);

  localparam int unsigned ProdW = DATA_WIDTH + WEIGHT_WIDTH;

  beam_state_e                 state_q;
  logic [IdxW-1:0]             idx_q;
  logic [WEIGHT_WIDTH-1:0]     weight_q [NUM_CHANNELS];
  logic [NUM_CHANNELS*ProdW-1:0] prod_d, prod_q;
  logic                        prod_valid_q;
  logic [IdxW-1:0]             idx_pipe_q [ChW+1];
  logic                        accept;
  logic                        last_accept;

  // Signed sample times zero-extended weight; the exact product always fits in ProdW bits.
  function automatic logic [ProdW-1:0] weigh(input logic [DATA_WIDTH-1:0] s,
                                             input logic [WEIGHT_WIDTH-1:0] w);
    logic signed [ProdW:0] s_ext, w_ext, p;
    s_ext = {{(WEIGHT_WIDTH+1){s[DATA_WIDTH-1]}}, s};
    w_ext = {{(DATA_WIDTH+1){1'b0}}, w};
    p     = s_ext * w_ext;
    return p[ProdW-1:0];
  endfunction

  assign accept      = (state_q == StIdle || state_q == StRun) && enable && (&valid_b);
  assign last_accept = accept && (idx_q == IdxW'(NUM_SAMPLES - 1));

  always_comb begin
    prod_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      prod_d[c*ProdW +: ProdW] = weigh(delayed_flat[c*DATA_WIDTH +: DATA_WIDTH], weight_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        weight_q[c] <= '1;
      end
      for (int k = 0; k <= ChW; k++) begin
        idx_pipe_q[k] <= '0;
      end
    end else begin
      if (w_we && state_q == StIdle) begin
        weight_q[w_addr] <= w_data;
      end
      prod_valid_q <= accept;
      if (accept) begin
        prod_q <= prod_d;
        idx_q  <= last_accept ? '0 : idx_q + 1'b1;
      end
      // The index travels beside its set; it only matters where the valid bit is set.
      idx_pipe_q[0] <= idx_q;
      for (int k = 1; k <= ChW; k++) begin
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
      unique case (state_q)
        StIdle:  if (accept) state_q <= last_accept ? StFlush : StRun;
        StRun:   if (last_accept) state_q <= StFlush;
        StFlush: if (line_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  adder_tree #(
    .NUM_INPUTS(NUM_CHANNELS),
    .IN_WIDTH  (ProdW)
  ) u_tree (
    .clk_i     (clk),
    .reset_i   (reset),
    .in_flat_i (prod_q),
    .in_valid_i(prod_valid_q),
    .sum_o     (sum_out),
    .valid_o   (sum_valid)
  );

  assign sample_idx = idx_pipe_q[ChW];
  assign line_done  = sum_valid && (sample_idx == IdxW'(NUM_SAMPLES - 1));
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_beam_sum.sv
// Directed bench for beam_sum: a line-level reference model checked every cycle, plus
// hand-computed expectations for the headline scenarios.
module tb_beam_sum;

  localparam int NC = 16, DW = 16, WW = 8, NS = 256, LAT = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic [NC*DW-1:0]     delayed_flat = '0;
  logic [NC-1:0]        valid_b = '0;
  logic                 w_we = 1'b0;
  logic [3:0]           w_addr = '0;
  logic [WW-1:0]        w_data = '0;
  logic signed [27:0]   sum_out;
  logic                 sum_valid;
  logic [7:0]           sample_idx;
  logic                 line_done;
  logic                 busy;

  always #5 clk = ~clk;

  beam_sum #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC),
    .WEIGHT_WIDTH(WW),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .delayed_flat(delayed_flat),
    .valid_b     (valid_b),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .sum_out     (sum_out),
    .sum_valid   (sum_valid),
    .sample_idx  (sample_idx),
    .line_done   (line_done),
    .busy        (busy)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Reference model: every accepted set becomes one expected output LAT cycles later.
  typedef struct {
    int     cyc;
    longint sum;
    int     idx;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  int     cyc = 0;
  bit     started = 0, line_open = 0, flushing = 0, ld_flag = 0;
  int     m_idx = 0;
  int     m_w [NC];
  bit     m_take, m_was_idle;
  longint m_sum;
  exp_t   m_e;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      started   = 1;
      line_open = 0;
      flushing  = 0;
      ld_flag   = 0;
      m_idx     = 0;
      exp_q.delete();
      foreach (m_w[i]) m_w[i] = 255;
    end else if (started) begin
      m_was_idle = !line_open;
      m_take     = !flushing && enable && (valid_b == '1);
      if (m_take) begin
        m_sum = 0;
        for (int i = 0; i < NC; i++)
          m_sum += longint'($signed(delayed_flat[i*DW +: DW])) * m_w[i];
        m_e.cyc  = cyc + LAT;
        m_e.sum  = m_sum;
        m_e.idx  = m_idx;
        m_e.last = (m_idx == NS - 1);
        exp_q.push_back(m_e);
        line_open = 1;
        if (m_idx == NS - 1) begin
          flushing = 1;
          m_idx    = 0;
        end else begin
          m_idx++;
        end
      end
      if (w_we && m_was_idle) m_w[w_addr] = w_data;
      if (ld_flag) begin
        line_open = 0;
        flushing  = 0;
        ld_flag   = 0;
      end
    end
    cyc++;
  end

  // Observations captured from the DUT for the hand-computed checks.
  int     n_valid = 0, last_idx = -1, last_cyc = -1;
  int     ld_cyc = -100, ld_idx = -1, busy_after_ld = -1;
  bit     ld_seen = 0;
  longint last_sum = 0;
  exp_t   c_e;

  initial forever begin
    @(negedge clk);
    if (started) begin
      if (sum_valid === 1'b1) begin
        n_valid++;
        last_sum = sum_out;
        last_idx = sample_idx;
        last_cyc = cyc;
      end
      if (line_done === 1'b1) begin
        ld_seen = 1;
        ld_cyc  = cyc;
        ld_idx  = sample_idx;
      end
      if (cyc == ld_cyc + 1) busy_after_ld = busy;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        c_e = exp_q.pop_front();
        check("sum_valid", sum_valid, 1);
        check("sum_out", sum_out, c_e.sum);
        check("sample_idx", sample_idx, c_e.idx);
        check("line_done", line_done, c_e.last);
        if (c_e.last) ld_flag = 1;
      end else begin
        check("sum_valid_idle", sum_valid, 0);
        check("line_done_idle", line_done, 0);
      end
      check("busy", busy, line_open);
    end
  end

  int acc_cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    enable  = 1'b0;
    valid_b = '0;
    w_we    = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rst(input int n);
    repeat (n) begin
      reset = 1'b1;
      step();
    end
  endtask

  task automatic pack_all(input int v);
    for (int i = 0; i < NC; i++) delayed_flat[i*DW +: DW] = DW'(v);
  endtask

  task automatic accept_one();
    enable  = 1'b1;
    valid_b = '1;
    acc_cyc = cyc;
    step();
  endtask

  task automatic wr(input int a, input int d);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = 8'(d);
    step();
  endtask

  int base, t0, gaps;

  initial begin
    rst(2);
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_sample_idx", sample_idx, 0);

    // Uniform 255 weights, all channels 100.
    base = n_valid;
    pack_all(100);
    accept_one();
    t0 = acc_cyc;
    pack_all(0);
    idle(8);
    check("uni_count", n_valid - base, 1);
    check("uni_sum", last_sum, 408000);
    check("uni_idx", last_idx, 0);
    check("uni_latency", last_cyc - t0, 5);

    // Ramp weights written in IDLE; a write while running is dropped.
    rst(1);
    for (int i = 0; i < NC; i++) wr(i, i);
    base = n_valid;
    pack_all(1);
    accept_one();
    idle(6);
    check("ramp_sum0", last_sum, 120);
    check("ramp_idx0", last_idx, 0);
    wr(0, 0);
    accept_one();
    idle(6);
    check("ramp_sum1", last_sum, 120);
    check("ramp_idx1", last_idx, 1);
    check("ramp_count", n_valid - base, 2);

    // Most negative samples at full weight.
    rst(1);
    pack_all(-32768);
    accept_one();
    idle(6);
    check("neg_sum", last_sum, -133693440);

    // Partial valid_b never accepts.
    rst(1);
    base = n_valid;
    pack_all(7);
    repeat (3) begin
      enable  = 1'b1;
      valid_b = 16'h7FFF;
      step();
    end
    accept_one();
    t0 = acc_cyc;
    idle(8);
    check("partial_count", n_valid - base, 1);
    check("partial_idx", last_idx, 0);
    check("partial_latency", last_cyc - t0, 5);
    check("partial_sum", last_sum, 7 * 255 * 16);

    // Full scanline with random gaps, then accept conditions held through FLUSH.
    rst(1);
    base    = n_valid;
    ld_seen = 0;
    for (int s = 0; s < NS; s++) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        if ($urandom_range(0, 1) == 1) begin
          enable  = 1'b1;
          valid_b = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15));
        end else begin
          valid_b = '1;
        end
        step();
      end
      for (int c = 0; c < NC; c++) delayed_flat[c*DW +: DW] = 16'($urandom);
      accept_one();
    end
    t0 = acc_cyc;
    repeat (5) begin
      enable  = 1'b1;
      valid_b = '1;
      step();
    end
    idle(8);
    check("line_count", n_valid - base, 256);
    check("line_done_seen", ld_seen, 1);
    check("line_done_idx", ld_idx, 255);
    check("line_done_latency", ld_cyc - t0, 5);
    check("busy_after_line", busy_after_ld, 0);
    check("busy_final", busy, 0);

    // Reset mid-line discards in-flight sets and restores weights.
    rst(1);
    for (int i = 0; i < NC; i++) wr(i, 3);
    pack_all(2);
    repeat (11) accept_one();
    idle(1);
    rst(1);
    base = n_valid;
    idle(10);
    check("mid_rst_count", n_valid - base, 0);
    check("mid_rst_busy", busy, 0);
    pack_all(1);
    accept_one();
    idle(6);
    check("post_rst_sum", last_sum, 4080);
    check("post_rst_idx", last_idx, 0);
    check("post_rst_count", n_valid - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
